branch_resolve_predict_unit: RTL and testbench
==============================================

Name: branch_resolve_predict_unit

Overview:
Parametrised successor to the combinational branch evaluator. It resolves conditional branches, JAL and JALR against register operands, with one registered pipeline stage. It also holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that supplies predictions to fetch and is trained at resolve time. It sits between the execute stage and the fetch redirect logic, and flags mispredictions together with the correct redirect PC.

Parameters:
XLEN, 32, datapath and PC width; legal values 32 or 64.
BHT_DEPTH, 64, number of BHT counters; a power of two, at least 2.
BHT_INIT, 2'b01, reset value of every counter (01 = weakly not-taken).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous squash of the output stage.
pred_pc  in  XLEN  fetch PC to look up.
pred_taken  out  1  combinational prediction: MSB of the indexed counter.
res_valid  in  1  resolve request valid this cycle.
res_type  in  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved.
res_funct3  in  3  branch condition code (RV32I encoding).
res_pc  in  XLEN  PC of the control-transfer instruction.
res_rs1  in  XLEN  rs1 operand.
res_rs2  in  XLEN  rs2 operand.
res_imm  in  XLEN  sign-extended immediate.
res_pred_taken  in  1  direction predicted at fetch.
res_pred_target  in  XLEN  target predicted at fetch.
out_valid  out  1  registered result valid.
out_taken  out  1  resolved direction.
out_target  out  XLEN  computed target.
out_link  out  XLEN  res_pc+4, the rd writeback value.
out_redirect_pc  out  XLEN  correct next PC.
out_mispredict  out  1  fetch must redirect to out_redirect_pc.
out_misaligned  out  1  taken target has bit 1 set.
out_illegal  out  1  funct3 010/011 on a branch, or res_type 11.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All out_* registers clear to 0.
  - Every BHT counter is set to BHT_INIT.
  - A resolve in flight is discarded.
- Latency: a request sampled at edge N appears on the out_* ports after edge N, valid for exactly one cycle unless another request follows.
- out_valid: registered from res_valid & ~flush. If flush is high at the edge, out_valid is 0 and the BHT is not updated.
- Conditions:
  - funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - JAL and JALR are always taken.
- Targets, all arithmetic modulo 2^XLEN (wrap-around, no overflow flag):
  - Branch and JAL: res_pc+res_imm.
  - JALR: (res_rs1+res_imm) with bit 0 cleared.
  - out_link = res_pc+4 for every type.
- out_redirect_pc = out_taken ? out_target : out_link.
- out_mispredict = valid & ~illegal & ((taken != res_pred_taken) | (taken & target != res_pred_target)).
- out_misaligned: set only when taken and target bit 1 is 1. It does not suppress out_mispredict; the trap logic takes priority downstream.
- Illegal request: taken = 0, mispredict = 0, misaligned = 0, out_illegal = 1, no BHT update.
- BHT index: pc[log2(BHT_DEPTH)+1:2], the same function for pred_pc and res_pc.
- BHT update:
  - Applies only for res_valid & ~flush & res_type==00 & legal funct3, at the same edge as the output register.
  - Taken: saturating increment, stopping at 11. Not taken: saturating decrement, stopping at 00.
  - JAL and JALR never touch the BHT.
- Simultaneous lookup and update of the same index: pred_taken reflects the pre-update counter (no bypass). The new value is visible from the next cycle.
- Back-to-back requests every cycle are supported, with no stall and no ready signal.
- reset_n asserted mid-stream: the output clears immediately, without waiting for a clock edge.

Test Plan:
- Reset, then pred_pc=0x100 → pred_taken=0. Cycle after reset release: out_valid=0 and all outputs 0.
- BEQ, pc=0x1000, rs1=rs2=5, imm=0x20, pred_taken=0 → next cycle: out_taken=1, out_target=0x1020, out_redirect_pc=0x1020, out_mispredict=1, out_link=0x1004.
- BLT with rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken. BGEU with the same operands → taken.
- Training: three taken BEQs at pc=0x40 (BHT_DEPTH=64) → counter goes 01→10→11→11, and pred_taken for 0x40 becomes 1 after the first update. A lookup in the same cycle as the first update still returns 0.
- JALR, rs1=0x2003, imm=0 → target 0x2002, out_misaligned=1. JAL, pc=0xFFFFFFFC, imm=8 → target wraps to 0x4.
- funct3=010 with res_valid=1 → out_illegal=1, out_mispredict=0, counter unchanged. res_valid together with flush → out_valid=0, BHT unchanged.

Source files
------------

// File: rtl/branch_resolve_predict_unit.sv
// branch_resolve_predict_unit
//   Resolves conditional branches, JAL and JALR one cycle after the request
//   and flags mispredictions with the correct redirect PC. It also holds a
//   direct-mapped table of 2-bit saturating counters. Fetch reads the table
//   combinationally, and resolved conditional branches train it.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   squashes the request being sampled this edge
//   pred_pc / pred_taken    fetch-side lookup (MSB of the indexed counter)
//   res_*                   resolve request (type, funct3, pc, operands,
//                           immediate, fetch-time prediction)
//   out_*                   registered resolve result, valid for one cycle

module branch_resolve_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [1:0]      res_type,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic [XLEN-1:0] res_imm,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            out_valid,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_mispredict,
  output logic            out_misaligned,
  output logic            out_illegal
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] BIT0_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       bht_q [BHT_DEPTH];

  logic            is_branch;
  logic            cond;
  logic            illegal;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            mispredict;
  logic            misaligned;
  logic            load;
  logic            bht_upd;

  logic            valid_q, taken_q, mispredict_q, misaligned_q, illegal_q;
  logic [XLEN-1:0] target_q, link_q, redirect_q;

  // Only the index bits of pred_pc matter; the rest are intentionally ignored.
  logic unused_pred_pc;
  assign unused_pred_pc = ^pred_pc;

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign res_idx    = res_pc[IDX_W+1:2];
  // No bypass: a same-cycle update becomes visible on the next cycle.
  assign pred_taken = bht_q[pred_idx][1];

  always_comb begin
    is_branch = (res_type == 2'b00);
    cond      = 1'b0;
    case (res_funct3)
      3'b000:  cond = (res_rs1 == res_rs2);
      3'b001:  cond = (res_rs1 != res_rs2);
      3'b100:  cond = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  cond = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  cond = (res_rs1 <  res_rs2);
      3'b111:  cond = (res_rs1 >= res_rs2);
      default: cond = 1'b0;
    endcase

    illegal = (res_type == 2'b11) | (is_branch & (res_funct3[2:1] == 2'b01));

    taken = 1'b0;
    case (res_type)
      2'b00:   taken = cond;
      2'b01,
      2'b10:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (illegal) taken = 1'b0;

    if (res_type == 2'b10) target = (res_rs1 + res_imm) & BIT0_CLR;
    else                   target = res_pc + res_imm;
    link = res_pc + XLEN'(4);

    mispredict = ~illegal & ((taken != res_pred_taken) |
                             (taken & (target != res_pred_target)));
    // Reported alongside mispredict; trap handling downstream has priority.
    misaligned = taken & target[1];

    load    = res_valid & ~flush;
    bht_upd = load & is_branch & ~illegal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      redirect_q   <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (load) begin
      valid_q      <= 1'b1;
      taken_q      <= taken;
      target_q     <= target;
      link_q       <= link;
      redirect_q   <= taken ? target : link;
      mispredict_q <= mispredict;
      misaligned_q <= misaligned;
      illegal_q    <= illegal;
    end else begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      redirect_q   <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (bht_upd) begin
      if (cond && bht_q[res_idx] != 2'b11)
        bht_q[res_idx] <= bht_q[res_idx] + 2'b01;
      else if (!cond && bht_q[res_idx] != 2'b00)
        bht_q[res_idx] <= bht_q[res_idx] - 2'b01;
    end
  end

  assign out_valid       = valid_q;
  assign out_taken       = taken_q;
  assign out_target      = target_q;
  assign out_link        = link_q;
  assign out_redirect_pc = redirect_q;
  assign out_mispredict  = mispredict_q;
  assign out_misaligned  = misaligned_q;
  assign out_illegal     = illegal_q;

endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
module tb_branch_resolve_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] pred_pc = 32'h100;
  logic        pred_taken;
  logic        res_valid = 1'b0;
  logic [1:0]  res_type = 2'b00;
  logic [2:0]  res_funct3 = 3'b000;
  logic [31:0] res_pc = '0, res_rs1 = '0, res_rs2 = '0, res_imm = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = '0;
  logic        out_valid, out_taken, out_mispredict, out_misaligned, out_illegal;
  logic [31:0] out_target, out_link, out_redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        tgt_dc;
    logic [31:0] link;
    logic [31:0] redirect;
    logic        mis;
    logic        mal;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  branch_resolve_predict_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .res_valid       (res_valid),
    .res_type        (res_type),
    .res_funct3      (res_funct3),
    .res_pc          (res_pc),
    .res_rs1         (res_rs1),
    .res_rs2         (res_rs2),
    .res_imm         (res_imm),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .out_valid       (out_valid),
    .out_taken       (out_taken),
    .out_target      (out_target),
    .out_link        (out_link),
    .out_redirect_pc (out_redirect_pc),
    .out_mispredict  (out_mispredict),
    .out_misaligned  (out_misaligned),
    .out_illegal     (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_taken", 64'(out_taken), 64'(e.taken));
        if (!e.tgt_dc) check("out_target", 64'(out_target), 64'(e.target));
        check("out_link", 64'(out_link), 64'(e.link));
        check("out_redirect_pc", 64'(out_redirect_pc), 64'(e.redirect));
        check("out_mispredict", 64'(out_mispredict), 64'(e.mis));
        check("out_misaligned", 64'(out_misaligned), 64'(e.mal));
        check("out_illegal", 64'(out_illegal), 64'(e.ill));
      end
    end
  end

  task automatic drive(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptg, input logic fl, input logic push,
                       input logic e_tk, input logic [31:0] e_tg, input logic e_dc,
                       input logic [31:0] e_lk, input logic [31:0] e_rd,
                       input logic e_mis, input logic e_mal, input logic e_ill);
    res_valid = 1'b1; flush = fl;
    res_type = t; res_funct3 = f3; res_pc = pc;
    res_rs1 = rs1; res_rs2 = rs2; res_imm = imm;
    res_pred_taken = pt; res_pred_target = ptg;
    if (push) sb.push_back('{e_tk, e_tg, e_dc, e_lk, e_rd, e_mis, e_mal, e_ill});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    // Reset and lookup while reset is held.
    #1 reset_n = 1'b0;
    #1 check("pred_taken_reset", 64'(pred_taken), 64'd0);
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    check("out_valid_after_reset", 64'(out_valid), 64'd0);
    check("out_target_after_reset", 64'(out_target), 64'd0);
    check("out_redirect_after_reset", 64'(out_redirect_pc), 64'd0);
    step();

    // Back-to-back resolves; pcs 0x1000/0x2000/0x3000 all map to index 0.
    drive(2'b00, 3'b000, 32'h1000, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1,
          1'b1, 32'h1020, 1'b0, 32'h1004, 32'h1020, 1'b1, 1'b0, 1'b0); step();
    drive(2'b00, 3'b100, 32'h2000, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h2010, 1'b0, 1'b1,
          1'b1, 32'h2010, 1'b0, 32'h2004, 32'h2010, 1'b0, 1'b0, 1'b0); step();
    drive(2'b00, 3'b110, 32'h2000, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 32'h2010, 1'b0, 1'b1,
          1'b0, 32'h2010, 1'b0, 32'h2004, 32'h2004, 1'b1, 1'b0, 1'b0); step();
    drive(2'b00, 3'b111, 32'h2000, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1,
          1'b1, 32'h2010, 1'b0, 32'h2004, 32'h2010, 1'b1, 1'b0, 1'b0); step();
    drive(2'b00, 3'b001, 32'h3000, 32'd7, 32'd7, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1,
          1'b0, 32'h3100, 1'b0, 32'h3004, 32'h3004, 1'b0, 1'b0, 1'b0); step();
    drive(2'b00, 3'b101, 32'h3000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 32'h2FF4, 1'b0, 1'b1,
          1'b1, 32'h2FF0, 1'b0, 32'h3004, 32'h2FF0, 1'b1, 1'b0, 1'b0); step();
    drive(2'b10, 3'b000, 32'h500, 32'h2003, 32'd0, 32'h0, 1'b1, 32'h2002, 1'b0, 1'b1,
          1'b1, 32'h2002, 1'b0, 32'h504, 32'h2002, 1'b0, 1'b1, 1'b0); step();
    drive(2'b01, 3'b000, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h8, 1'b1, 32'h4, 1'b0, 1'b1,
          1'b1, 32'h4, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0); step();
    idle();

    // Index 0 saw T,T,N,T,N,T: 01->10->11->10->11->10->11.
    pred_pc = 32'h0;
    #1 check("pred_idx0_trained", 64'(pred_taken), 64'd1);
    pred_pc = 32'h40;
    #1 check("pred_0x40_init", 64'(pred_taken), 64'd0);
    step();

    // First training update at 0x40; same-cycle lookup sees the old counter.
    drive(2'b00, 3'b000, 32'h40, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1,
          1'b1, 32'h48, 1'b0, 32'h44, 32'h48, 1'b1, 1'b0, 1'b0);
    #1 check("pred_same_cycle_update", 64'(pred_taken), 64'd0);
    step(); idle();
    check("pred_after_first_train", 64'(pred_taken), 64'd1);

    // Illegal funct3 and reserved type: no BHT update (counter 10 stays).
    drive(2'b00, 3'b010, 32'h40, 32'd0, 32'd0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1,
          1'b0, 32'h40, 1'b1, 32'h44, 32'h44, 1'b0, 1'b0, 1'b1); step();
    drive(2'b11, 3'b000, 32'h40, 32'd0, 32'd0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1,
          1'b0, 32'h0, 1'b1, 32'h44, 32'h44, 1'b0, 1'b0, 1'b1); step();
    idle();
    check("pred_after_illegal", 64'(pred_taken), 64'd1);

    // Flushed not-taken branch: no output, no BHT update.
    drive(2'b00, 3'b000, 32'h40, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0,
          1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); step();
    idle();
    check("out_valid_flushed", 64'(out_valid), 64'd0);
    check("pred_after_flush", 64'(pred_taken), 64'd1);

    // Two more taken: 10->11->11 (saturate).
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 3'b000, 32'h40, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1,
            1'b1, 32'h48, 1'b0, 32'h44, 32'h48, 1'b1, 1'b0, 1'b0); step();
      check("pred_train_taken", 64'(pred_taken), 64'd1);
    end
    // Two not-taken: 11->10 (pred 1) -> 01 (pred 0).
    drive(2'b00, 3'b000, 32'h40, 32'd1, 32'd2, 32'h8, 1'b1, 32'h48, 1'b0, 1'b1,
          1'b0, 32'h48, 1'b0, 32'h44, 32'h44, 1'b1, 1'b0, 1'b0); step();
    check("pred_after_dec1", 64'(pred_taken), 64'd1);
    drive(2'b00, 3'b000, 32'h40, 32'd1, 32'd2, 32'h8, 1'b1, 32'h48, 1'b0, 1'b1,
          1'b0, 32'h48, 1'b0, 32'h44, 32'h44, 1'b1, 1'b0, 1'b0); step();
    check("pred_after_dec2", 64'(pred_taken), 64'd0);

    // JAL at the same pc must not train the counter (01 stays).
    drive(2'b01, 3'b000, 32'h40, 32'd0, 32'd0, 32'h10, 1'b1, 32'h50, 1'b0, 1'b1,
          1'b1, 32'h50, 1'b0, 32'h44, 32'h50, 1'b0, 1'b0, 1'b0); step();
    idle();
    check("pred_after_jal", 64'(pred_taken), 64'd0);

    // Decrement saturation: 01->00->00, then one taken -> 01 (pred 0).
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 3'b000, 32'h40, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1,
            1'b0, 32'h48, 1'b0, 32'h44, 32'h44, 1'b0, 1'b0, 1'b0); step();
      check("pred_train_not_taken", 64'(pred_taken), 64'd0);
    end
    drive(2'b00, 3'b000, 32'h40, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1,
          1'b1, 32'h48, 1'b0, 32'h44, 32'h48, 1'b1, 1'b0, 1'b0); step();
    idle();
    check("pred_after_floor_inc", 64'(pred_taken), 64'd0);
    step();

    // Mid-stream asynchronous reset clears output and BHT without a clock edge.
    pred_pc = 32'h0;
    drive(2'b00, 3'b000, 32'h0, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0,
          1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); step();
    idle();
    check("out_valid_before_async_reset", 64'(out_valid), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("out_valid_async_reset", 64'(out_valid), 64'd0);
    check("out_taken_async_reset", 64'(out_taken), 64'd0);
    check("out_target_async_reset", 64'(out_target), 64'd0);
    check("pred_idx0_async_reset", 64'(pred_taken), 64'd0);
    step();
    reset_n = 1'b1;
    step(); step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
